// File: rtl/sort_pkg.sv
// Shared constants and the host FSM state type for the sort host controller.
package sort_pkg;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = ADDR_W + 1;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RESTART,
    START,
    ARM,
    SORT,
    UNL_RD,
    UNL_OUT
  } host_state_t;
endpackage

// File: rtl/sort_ram.sv
// Single-port synchronous RAM: registered read, old data returned on read-during-write.
module sort_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sort_host_ctrl.sv
// Host controller and RAM owner for the bubble_sort engine: load, sort, unload.
// Define SORT_CYCLE_CNT_EN to add the sort_cycles duration counter output.
module sort_host_ctrl
  import sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              sort_rst_n,
  output logic              sort_enable,
  input  logic              sort_ready,
  output logic [LEN_W-1:0]  sort_length,
  input  logic [ADDR_W-1:0] sort_address,
  input  logic              sort_wren,
  input  logic [DATA_W-1:0] sort_wdata,
  output logic [DATA_W-1:0] sort_rdata
`ifdef SORT_CYCLE_CNT_EN
  ,
  output logic [31:0]       sort_cycles
`endif
);
  host_state_t       state;
  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] index;
  logic              out_vld_q;
  logic              out_last_q;
  logic              in_fire;
  logic              sorter_owns;
  logic              unloading;
  logic              sort_phase;
  logic [ADDR_W-1:0] host_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign sorter_owns = (state == ARM) || (state == SORT);
  assign unloading   = (state == UNL_RD) || (state == UNL_OUT);
  assign sort_phase  = (state == RESTART) || (state == START) || sorter_owns;

  assign in_ready = ~rst & ((state == IDLE) || ((state == LOAD) && (count < DEPTH_L)));
  assign in_fire  = in_valid & in_ready;

  // Host keeps addressing the current element through UNL_OUT so rdata stays stable.
  assign host_addr = unloading ? index : count[ADDR_W-1:0];
  assign ram_addr  = sorter_owns ? sort_address : host_addr;
  assign ram_we    = sorter_owns ? sort_wren : in_fire;
  assign ram_wdata = sorter_owns ? sort_wdata : in_data;

  sort_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign sort_rdata  = ram_rdata;
  assign busy        = ~rst & (state != IDLE);
  assign sort_rst_n  = ~rst & (state != RESTART);
  assign sort_enable = ~rst & (state == START);
  assign sort_length = sort_phase ? count : '0;
  assign out_valid   = ~rst & out_vld_q;
  assign out_last    = ~rst & out_last_q;
  assign out_data    = out_valid ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          count <= LEN_W'(1);
          state <= in_last ? RESTART : LOAD;
        end
        LOAD: if (in_fire) begin
          count <= count + LEN_W'(1);
          if (in_last || (count + LEN_W'(1) == DEPTH_L)) state <= RESTART;
        end
        // Arrays shorter than two bypass the sorter, whose pass bound would underflow.
        RESTART: begin
          index <= '0;
          state <= (count < LEN_W'(2)) ? UNL_RD : START;
        end
        START: state <= ARM;
        ARM:   if (!sort_ready) state <= SORT;
        SORT: if (sort_ready) begin
          index <= '0;
          state <= UNL_RD;
        end
        UNL_RD: begin
          out_vld_q  <= 1'b1;
          out_last_q <= ({1'b0, index} == count - LEN_W'(1));
          state      <= UNL_OUT;
        end
        UNL_OUT: if (out_ready) begin
          out_vld_q  <= 1'b0;
          out_last_q <= 1'b0;
          index      <= index + ADDR_W'(1);
          if (out_last_q) begin
            count <= '0;
            state <= IDLE;
          end else begin
            state <= UNL_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sort_cycles <= '0;
    end else if (state == START) begin
      sort_cycles <= '0;
    end else if (sorter_owns && (sort_cycles != 32'hFFFF_FFFF)) begin
      sort_cycles <= sort_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sort_host_ctrl.sv
// Bench for sort_host_ctrl: stand-in sorter on the memory port, sorted-queue reference model.
module tb_sort_host_ctrl;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       sort_rst_n;
  logic       sort_enable;
  logic       sort_ready;
  logic [8:0] sort_length;
  logic [7:0] sort_address;
  logic       sort_wren;
  logic [7:0] sort_wdata;
  logic [7:0] sort_rdata;
`ifdef SORT_CYCLE_CNT_EN
  logic [31:0] sort_cycles;
`endif

  logic [7:0] sr_addr;
  logic [7:0] sr_wdata;
  logic       sr_wren;
  logic       sr_ready;
  logic       junk_wr;
  int         en_cnt;
  int         len_seen;
  bit         sr_active;

  int n_checks;
  int n_fail;
  int acc_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  assign sort_ready   = sr_ready;
  assign sort_address = junk_wr ? 8'h07 : sr_addr;
  assign sort_wdata   = junk_wr ? 8'hEE : sr_wdata;
  assign sort_wren    = sr_wren | junk_wr;

  sort_host_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .sort_rst_n   (sort_rst_n),
    .sort_enable  (sort_enable),
    .sort_ready   (sort_ready),
    .sort_length  (sort_length),
    .sort_address (sort_address),
    .sort_wren    (sort_wren),
    .sort_wdata   (sort_wdata),
    .sort_rdata   (sort_rdata)
`ifdef SORT_CYCLE_CNT_EN
    ,
    .sort_cycles  (sort_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in sorter: reads the whole array, sorts it, writes it back, then raises ready.
  initial begin
    sr_addr = '0; sr_wdata = '0; sr_wren = 1'b0; sr_ready = 1'b1;
    en_cnt = 0; len_seen = 0; sr_active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sort_enable && sort_rst_n) begin
        automatic int n = int'(sort_length);
        automatic logic [7:0] buf_q[$];
        en_cnt++;
        len_seen  = n;
        sr_ready  = 1'b0;
        sr_active = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n && sort_rst_n; i++) begin
          sr_addr = 8'(i);
          @(posedge clk); #1;
          buf_q.push_back(sort_rdata);
        end
        buf_q.sort();
        for (int i = 0; i < n && sort_rst_n && buf_q.size() == n; i++) begin
          sr_addr  = 8'(i);
          sr_wdata = buf_q[i];
          sr_wren  = 1'b1;
          @(posedge clk); #1;
        end
        sr_wren   = 1'b0;
        sr_ready  = 1'b1;
        sr_active = 1'b0;
      end
    end
  end

  // Output monitor: every accepted beat must be the next smallest element still owed.
  logic       pv, pr;
  logic [7:0] pd;
  initial begin pv = 1'b0; pr = 1'b0; pd = '0; end
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(pd));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no output", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
          got_q.push_back(out_data);
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  task automatic load(input logic [7:0] vals[$], input bit use_last);
    logic [7:0] tmp[$];
    for (int i = 0; i < vals.size(); i++) begin
      automatic bit ok = 1'b0;
      automatic int t = 0;
      in_valid = 1'b1;
      in_data  = vals[i];
      in_last  = use_last && (i == vals.size() - 1);
      while (!ok && t < 50) begin
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) check("load_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tmp = vals;
    tmp.sort();
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input bit junk);
    int left = stall_len;
    int t = 0;
    while (busy && t < 3000) begin
      if (acc_cnt == stall_at && left > 0) begin
        out_ready = 1'b0;
        junk_wr   = junk;
        left--;
      end else begin
        out_ready = 1'b1;
        junk_wr   = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b1;
    junk_wr   = 1'b0;
    if (busy) check("done_timeout", 32'd0, 32'd1);
    check("all_out", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_got(input string name, input logic [7:0] e[$]);
    check({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      check(name, 32'(got_q[i]), 32'(e[i]));
  endtask

  initial begin
    logic [7:0] v[$];
    logic [7:0] e[$];
    int en0;
    n_checks = 0; n_fail = 0; acc_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; junk_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sort_enable", 32'(sort_enable), 32'd0);
    check("rst_sort_rst_n", 32'(sort_rst_n), 32'd0);
    check("rst_sort_length", 32'(sort_length), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_sort_rst_n", 32'(sort_rst_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Five-element array through the sorter
    got_q.delete(); en0 = en_cnt;
    v = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7};
    load(v, 1'b1);
    check("t1_restart_rst_n", 32'(sort_rst_n), 32'd0);
    check("t1_in_ready_low", 32'(in_ready), 32'd0);
    wait_done(-1, 0, 1'b0);
    check("t1_enable_cnt", 32'(en_cnt - en0), 32'd1);
    check("t1_length", 32'(len_seen), 32'd5);
    check("t1_busy", 32'(busy), 32'd0);
    e = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
    check_got("t1_seq", e);
`ifdef SORT_CYCLE_CNT_EN
    check("t1_cycles_nonzero", 32'(sort_cycles != 32'd0), 32'd1);
`endif

    // Single element bypasses the sorter
    got_q.delete(); en0 = en_cnt;
    v = '{8'h42};
    load(v, 1'b1);
    wait_done(-1, 0, 1'b0);
    check("t2_enable_cnt", 32'(en_cnt - en0), 32'd0);
    e = '{8'h42};
    check_got("t2_seq", e);

    // Full 256-entry array with no in_last
    got_q.delete(); en0 = en_cnt;
    v.delete();
    for (int i = 255; i >= 0; i--) v.push_back(8'(i));
    load(v, 1'b0);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    wait_done(-1, 0, 1'b0);
    check("t3_enable_cnt", 32'(en_cnt - en0), 32'd1);
    check("t3_length", 32'(len_seen), 32'd256);
    e.delete();
    for (int i = 0; i < 256; i++) e.push_back(8'(i));
    check_got("t3_seq", e);

    // Backpressure mid-stream, with stray sorter writes that must be ignored
    got_q.delete(); acc_cnt = 0;
    v = '{8'd10, 8'd200, 8'd30, 8'd4, 8'd150, 8'd77, 8'd0, 8'd255};
    load(v, 1'b1);
    wait_done(3, 10, 1'b1);
    e = '{8'd0, 8'd4, 8'd10, 8'd30, 8'd77, 8'd150, 8'd200, 8'd255};
    check_got("t4_seq", e);

    // Reset while the sorter is working, then a fresh two-element run
    got_q.delete();
    v = '{8'd6, 8'd5, 8'd4, 8'd3};
    load(v, 1'b1);
    for (int t = 0; t < 50 && !sr_active; t++) begin
      @(posedge clk); #1;
    end
    check("t5_sorter_active", 32'(sr_active), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_sort_rst_n", 32'(sort_rst_n), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_idle_in_ready", 32'(in_ready), 32'd1);
    check("t5_idle_busy", 32'(busy), 32'd0);
    v = '{8'd2, 8'd1};
    load(v, 1'b1);
    check("t5_restart_rst_n", 32'(sort_rst_n), 32'd0);
    wait_done(-1, 0, 1'b0);
    e = '{8'd1, 8'd2};
    check_got("t5_seq", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
